// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths and mem_size encodings for the pipeline
package pipeline_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/dm_lane_ctrl.sv
// rtl/dm_lane_ctrl.sv - byte-enable/store-word steering and load extraction for a 32-bit word memory
module dm_lane_ctrl
  import pipeline_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] read_word,
  output logic [3:0]        byte_en,
  output logic [DATA_W-1:0] write_word,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = read_word[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? read_word[31:16] : read_word[15:0];

  // Low address bits that do not fit the access size are simply ignored here.
  always_comb begin
    byte_en    = 4'b0000;
    write_word = store_data;
    load_data  = '0;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        write_word = {4{store_data[7:0]}};
        load_data  = is_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      end
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        write_word = {2{store_data[15:0]}};
        load_data  = is_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      end
      default: begin
        byte_en    = 4'b1111;
        write_word = store_data;
        load_data  = read_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with data memory and MEM/WB registers; MEM_MISALIGN_TRAP_EN enables misalign trapping
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int DM_DEPTH = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd_in_mem,
  input  logic              reg_write_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg_in,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [DATA_W-1:0] alu_data_out,
  output logic [DATA_W-1:0] dm_data_out,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic [REG_W-1:0]  rd_out_mem,
  output logic              misalign
);

  logic [DATA_W-1:0] mem [DM_DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [DATA_W-1:0] read_word;
  logic [3:0]        byte_en;
  logic [DATA_W-1:0] write_word;
  logic [DATA_W-1:0] load_data;
  logic              mis_access;
  logic              do_write;

  assign word_idx  = alu_result[ADDR_W+1:2];
  assign read_word = mem[word_idx];

  dm_lane_ctrl u_lane (
    .size        (mem_size),
    .addr_lo     (alu_result[1:0]),
    .is_unsigned (mem_unsigned),
    .store_data  (store_data),
    .read_word   (read_word),
    .byte_en     (byte_en),
    .write_word  (write_word),
    .load_data   (load_data)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  // Reserved size 2'b11 behaves as a word, hence the mem_size[1] test.
  assign mis_access = (mem_read | mem_write) &
                      (((mem_size == SZ_HALF) & alu_result[0]) |
                       (mem_size[1] & (|alu_result[1:0])));
`else
  assign mis_access = 1'b0;
`endif

  assign do_write = reset & ~flush & ~stall & mem_write & ~mis_access;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= write_word[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      alu_data_out <= '0;
      dm_data_out  <= '0;
      mem_to_reg   <= 1'b0;
      reg_write    <= 1'b0;
      rd_out_mem   <= '0;
      misalign     <= 1'b0;
    end else if (!stall) begin
      alu_data_out <= alu_result;
      // A combined read+write is treated as a store: no load data returned.
      dm_data_out  <= (mem_read && !mem_write && !mis_access) ? load_data : '0;
      mem_to_reg   <= mem_to_reg_in;
      reg_write    <= reg_write_in & ~(mis_access & mem_read);
      rd_out_mem   <= rd_in_mem;
      misalign     <= mis_access;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in_mem;
  logic        reg_write_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg_in;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] alu_data_out;
  logic [31:0] dm_data_out;
  logic        mem_to_reg;
  logic        reg_write;
  logic [4:0]  rd_out_mem;
  logic        misalign;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .rd_in_mem     (rd_in_mem),
    .reg_write_in  (reg_write_in),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg_in (mem_to_reg_in),
    .mem_size      (mem_size),
    .mem_unsigned  (mem_unsigned),
    .alu_data_out  (alu_data_out),
    .dm_data_out   (dm_data_out),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .rd_out_mem    (rd_out_mem),
    .misalign      (misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; alu_result = 0; store_data = 0; rd_in_mem = 0;
    reg_write_in = 0; mem_read = 0; mem_write = 0; mem_to_reg_in = 0;
    mem_size = SZ_WORD; mem_unsigned = 0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    idle();
    alu_result = addr; store_data = data; mem_write = 1; mem_size = sz;
    tick();
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic uns, input logic [4:0] rd);
    idle();
    alu_result = addr; mem_read = 1; mem_size = sz; mem_unsigned = uns;
    rd_in_mem = rd; reg_write_in = 1; mem_to_reg_in = 1;
    tick();
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (2) begin
      alu_result = $urandom; store_data = $urandom; rd_in_mem = 5'($urandom);
      reg_write_in = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      mem_to_reg_in = 1'($urandom); mem_size = 2'($urandom); mem_unsigned = 1'($urandom);
      tick();
      check("rst_alu", alu_data_out, 0);
      check("rst_dm", dm_data_out, 0);
      check("rst_m2r", {31'b0, mem_to_reg}, 0);
      check("rst_rw", {31'b0, reg_write}, 0);
      check("rst_rd", {27'b0, rd_out_mem}, 0);
      check("rst_mis", {31'b0, misalign}, 0);
    end
    reset = 1;

    idle(); alu_result = 32'h1234; rd_in_mem = 5; reg_write_in = 1;
    tick();
    check("alu_pass", alu_data_out, 32'h1234);
    check("alu_rd", {27'b0, rd_out_mem}, 5);
    check("alu_rw", {31'b0, reg_write}, 1);
    check("alu_dm", dm_data_out, 0);

    store(32'h10, 32'hDEADBEEF, SZ_WORD);
    check("st_dm_zero", dm_data_out, 0);
    load(32'h10, SZ_WORD, 0, 7);
    check("ld_word", dm_data_out, 32'hDEADBEEF);
    check("ld_m2r", {31'b0, mem_to_reg}, 1);
    check("ld_rd", {27'b0, rd_out_mem}, 7);

    store(32'h13, 32'h12345680, SZ_BYTE);
    load(32'h13, SZ_BYTE, 0, 1);
    check("ld_sbyte", dm_data_out, 32'hFFFFFF80);
    load(32'h13, SZ_BYTE, 1, 1);
    check("ld_ubyte", dm_data_out, 32'h00000080);
    load(32'h10, SZ_WORD, 0, 1);
    check("ld_word_b", dm_data_out, 32'h80ADBEEF);

    store(32'h20, 32'h11223344, SZ_WORD);
    store(32'h22, 32'hABCD8001, SZ_HALF);
    load(32'h22, SZ_HALF, 0, 2);
    check("ld_shalf", dm_data_out, 32'hFFFF8001);
    load(32'h22, SZ_HALF, 1, 2);
    check("ld_uhalf", dm_data_out, 32'h00008001);
    load(32'h20, SZ_WORD, 0, 2);
    check("ld_word_h_up", {16'b0, dm_data_out[31:16]}, 32'h8001);
    check("ld_word_h", dm_data_out, 32'h80013344);
    load(32'h20, SZ_HALF, 0, 2);
    check("ld_half_lo", dm_data_out, 32'h00003344);

    // Stall: outputs from the previous load must hold, no write.
    load(32'h10, SZ_WORD, 0, 7);
    idle(); stall = 1; alu_result = 32'h11; store_data = 32'h55; mem_write = 1;
    mem_size = SZ_BYTE; rd_in_mem = 9; reg_write_in = 1;
    tick();
    check("stall_dm", dm_data_out, 32'h80ADBEEF);
    check("stall_alu", alu_data_out, 32'h10);
    check("stall_rd", {27'b0, rd_out_mem}, 7);
    load(32'h10, SZ_WORD, 0, 7);
    check("stall_nowr", dm_data_out, 32'h80ADBEEF);

    idle(); flush = 1; alu_result = 32'h10; mem_read = 1; rd_in_mem = 3; reg_write_in = 1;
    tick();
    check("flush_rw", {31'b0, reg_write}, 0);
    check("flush_rd", {27'b0, rd_out_mem}, 0);
    check("flush_dm", dm_data_out, 0);
    check("flush_alu", alu_data_out, 0);

    load(32'h10, SZ_WORD, 0, 4);
    idle(); flush = 1; stall = 1; alu_result = 32'h10; store_data = 32'h66;
    mem_write = 1; mem_size = SZ_BYTE; rd_in_mem = 4; reg_write_in = 1;
    tick();
    check("fs_rd", {27'b0, rd_out_mem}, 0);
    check("fs_dm", dm_data_out, 0);
    load(32'h10, SZ_WORD, 0, 4);
    check("fs_nowr", dm_data_out, 32'h80ADBEEF);

    idle(); alu_result = 32'h30; store_data = 32'hCAFEF00D; mem_read = 1; mem_write = 1;
    tick();
    check("rw_dm_zero", dm_data_out, 0);
    load(32'h30, SZ_WORD, 0, 6);
    check("rw_stored", dm_data_out, 32'hCAFEF00D);

    store(32'h430, 32'h0BADF00D, SZ_WORD);
    load(32'h30, SZ_WORD, 0, 6);
    check("wrap", dm_data_out, 32'h0BADF00D);

    store(32'h21, 32'hAABBCCDD, SZ_WORD);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_st_flag", {31'b0, misalign}, 1);
    load(32'h20, SZ_WORD, 0, 2);
    check("mis_st_mem", dm_data_out, 32'h80013344);
    check("mis_clear", {31'b0, misalign}, 0);
    load(32'h23, SZ_HALF, 0, 2);
    check("mis_ld_dm", dm_data_out, 0);
    check("mis_ld_rw", {31'b0, reg_write}, 0);
    check("mis_ld_flag", {31'b0, misalign}, 1);
`else
    check("mis_st_flag", {31'b0, misalign}, 0);
    load(32'h20, SZ_WORD, 0, 2);
    check("mis_st_mem", dm_data_out, 32'hAABBCCDD);
    load(32'h23, SZ_HALF, 0, 2);
    check("mis_ld_dm", dm_data_out, 32'hFFFFAABB);
    check("mis_ld_rw", {31'b0, reg_write}, 1);
    check("mis_ld_flag", {31'b0, misalign}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
